// File: rtl/bbc_bus_pkg.sv
// Shared types, address-region constants and sizing helpers for the BBC host-side bus model.
package bbc_bus_pkg;

    typedef enum logic {
        PH1,
        PH2
    } phase_e;

    // 1MHz-bus regions (FRED/JIM pages and the slow SHEILA sub-ranges) plus the local register window.
    localparam logic [15:0] FRED_BASE        = 16'hFC00;
    localparam logic [15:0] FRED_MASK        = 16'hFF00;
    localparam logic [15:0] JIM_BASE         = 16'hFD00;
    localparam logic [15:0] JIM_MASK         = 16'hFF00;
    localparam logic [15:0] SHEILA_FE00_BASE = 16'hFE00;
    localparam logic [15:0] SHEILA_FE00_MASK = 16'hFFE0;
    localparam logic [15:0] SHEILA_FE40_BASE = 16'hFE40;
    localparam logic [15:0] SHEILA_FE40_MASK = 16'hFFC0;
    localparam logic [15:0] SHEILA_FEC0_BASE = 16'hFEC0;
    localparam logic [15:0] SHEILA_FEC0_MASK = 16'hFFE0;
    localparam logic [15:0] FE4X_BASE        = 16'hFE40;
    localparam logic [15:0] FE4X_MASK        = 16'hFFF0;

    // Longest phase is a 4x-stretched phi2, so the counter must hold 4*CLK_DIV-1.
    function automatic int unsigned hi_cnt_width(input int unsigned clk_div);
        return $clog2(4 * clk_div);
    endfunction

    function automatic logic in_region(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input logic [15:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/bbc_region_decode.sv
// Combinational address decode: which cycles are stretched, and which hit the local register window.
module bbc_region_decode
    import bbc_bus_pkg::*;
(
    input  logic [15:0] i_addr,
    output logic        o_stretch,
    output logic        o_is_reg
);

    always_comb begin
        o_stretch = in_region(i_addr, FRED_BASE, FRED_MASK)
                  | in_region(i_addr, JIM_BASE, JIM_MASK)
                  | in_region(i_addr, SHEILA_FE00_BASE, SHEILA_FE00_MASK)
                  | in_region(i_addr, SHEILA_FE40_BASE, SHEILA_FE40_MASK)
                  | in_region(i_addr, SHEILA_FEC0_BASE, SHEILA_FEC0_MASK);
        o_is_reg  = in_region(i_addr, FE4X_BASE, FE4X_MASK);
    end

endmodule

// File: rtl/bbc_host_responder.sv
// Host end of the 6502-socket bus: phi0/phi1 generation, 1MHz stretching, &FE4x register window and memory port.
module bbc_host_responder
    import bbc_bus_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
)
(
    input  logic        hsclk,
    input  logic        resetb,
    output logic        bbc_phi0,
    output logic        bbc_phi1,
    input  logic [15:0] bbc_a,
    input  logic        bbc_rnw,
    input  logic        bbc_sync,
    input  logic [7:0]  bbc_d_in,
    output logic [7:0]  bbc_d_out,
    output logic        bbc_d_oe,
    output logic        irqb,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic [15:0] cyc_cnt,
    output logic [15:0] sync_cnt
);

    localparam int unsigned CNT_W = hi_cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST_1X = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_3X = CNT_W'(3 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_4X = CNT_W'(4 * CLK_DIV - 1);

    phase_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_hi_last;
    logic              r_phi0;
    logic              r_onemhz_ph;
    logic              r_rnw;
    logic              r_sync;
    logic              r_is_reg;
    logic [15:0]       r_mem_addr;
    logic              r_mem_rd;
    logic              r_mem_we;
    logic [7:0]        r_mem_wdata;
    logic [7:0]        r_d_out;
    logic              r_d_oe;
    logic              r_irqb;
    logic [15:0]       r_cyc_cnt;
    logic [15:0]       r_sync_cnt;
    logic [7:0]        r_regs [16];

    logic              w_stretch;
    logic              w_is_reg;

    bbc_region_decode u_decode (
        .i_addr    (bbc_a),
        .o_stretch (w_stretch),
        .o_is_reg  (w_is_reg)
    );

    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            r_state     <= PH1;
            r_cnt       <= '0;
            r_hi_last   <= LAST_1X;
            r_phi0      <= 1'b0;
            r_onemhz_ph <= 1'b0;
            r_rnw       <= 1'b1;
            r_sync      <= 1'b0;
            r_is_reg    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_d_out     <= '0;
            r_d_oe      <= 1'b0;
            r_irqb      <= 1'b1;
            r_cyc_cnt   <= '0;
            r_sync_cnt  <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_mem_rd <= 1'b0;
            r_mem_we <= 1'b0;
            r_irqb   <= ~r_regs[15][0];

            case (r_state)
                PH1: begin
                    if (r_cnt == LAST_1X) begin
                        // Everything about the cycle is decided from the address as seen here.
                        r_mem_addr  <= bbc_a;
                        r_rnw       <= bbc_rnw;
                        r_sync      <= bbc_sync;
                        r_is_reg    <= w_is_reg;
                        r_hi_last   <= w_stretch ? (r_onemhz_ph ? LAST_3X : LAST_4X) : LAST_1X;
                        r_onemhz_ph <= ~r_onemhz_ph;
                        r_phi0      <= 1'b1;
                        r_state     <= PH2;
                        r_cnt       <= '0;
                        if (bbc_rnw) begin
                            if (w_is_reg) begin
                                r_d_out <= r_regs[bbc_a[3:0]];
                                r_d_oe  <= 1'b1;
                            end else begin
                                r_mem_rd <= 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                PH2: begin
                    if (r_cnt == '0 && r_rnw && !r_is_reg) begin
                        r_d_out <= mem_rdata;
                        r_d_oe  <= 1'b1;
                    end
                    if (r_cnt == r_hi_last) begin
                        if (!r_rnw) begin
                            if (r_is_reg) begin
                                r_regs[r_mem_addr[3:0]] <= bbc_d_in;
                            end else begin
                                r_mem_wdata <= bbc_d_in;
                                r_mem_we    <= 1'b1;
                            end
                        end
                        r_d_oe    <= 1'b0;
                        r_cyc_cnt <= r_cyc_cnt + 16'd1;
                        if (r_sync) begin
                            r_sync_cnt <= r_sync_cnt + 16'd1;
                        end
                        r_phi0  <= 1'b0;
                        r_state <= PH1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= PH1;
                    r_cnt   <= '0;
                    r_phi0  <= 1'b0;
                end
            endcase
        end
    end

    assign bbc_phi0  = r_phi0;
    assign bbc_phi1  = ~r_phi0;
    assign bbc_d_out = r_d_out;
    assign bbc_d_oe  = r_d_oe;
    assign irqb      = r_irqb;
    assign mem_addr  = r_mem_addr;
    assign mem_rd    = r_mem_rd;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign cyc_cnt   = r_cyc_cnt;
    assign sync_cnt  = r_sync_cnt;

endmodule

// File: tb/tb_bbc_host_responder.sv
// Scoreboard bench for bbc_host_responder: directed bus cycles queue expectations, a negedge monitor checks them.
module tb_bbc_host_responder;

    localparam int unsigned CLK_DIV = 4;

    logic        hsclk = 1'b0;
    logic        resetb = 1'b0;
    logic        bbc_phi0, bbc_phi1;
    logic [15:0] bbc_a = '0;
    logic        bbc_rnw = 1'b1;
    logic        bbc_sync = 1'b0;
    logic [7:0]  bbc_d_in = '0;
    logic [7:0]  bbc_d_out;
    logic        bbc_d_oe;
    logic        irqb;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h3C;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [15:0] cyc_cnt, sync_cnt;

    always #5 hsclk = ~hsclk;

    bbc_host_responder #(.CLK_DIV(CLK_DIV)) dut (
        .hsclk     (hsclk),
        .resetb    (resetb),
        .bbc_phi0  (bbc_phi0),
        .bbc_phi1  (bbc_phi1),
        .bbc_a     (bbc_a),
        .bbc_rnw   (bbc_rnw),
        .bbc_sync  (bbc_sync),
        .bbc_d_in  (bbc_d_in),
        .bbc_d_out (bbc_d_out),
        .bbc_d_oe  (bbc_d_oe),
        .irqb      (irqb),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .cyc_cnt   (cyc_cnt),
        .sync_cnt  (sync_cnt)
    );

    typedef struct {
        int unsigned hi_len;
        int unsigned oe;
        logic [7:0]  dout;
        int unsigned rd;
        logic [15:0] addr;
        int unsigned we;
        logic [7:0]  wdata;
        bit          sync;
        bit          irq_next;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    logic [7:0]  regs_m [16];
    int unsigned idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit stretch_m(input logic [15:0] a);
        return (a >= 16'hFC00 && a <= 16'hFDFF) || (a >= 16'hFE00 && a <= 16'hFE1F) ||
               (a >= 16'hFE40 && a <= 16'hFE7F) || (a >= 16'hFEC0 && a <= 16'hFEDF);
    endfunction

    task automatic wait_phi(input logic lvl);
        int unsigned n = 0;
        while (bbc_phi0 !== lvl && n < 100) begin
            @(negedge hsclk);
            n++;
        end
        if (bbc_phi0 !== lvl) chk("phase_timeout", 32'(bbc_phi0), 32'(lvl));
    endtask

    task automatic model_reset();
        idx = 0;
        for (int i = 0; i < 16; i++) regs_m[i] = '0;
    endtask

    // One complete bus cycle; optionally scrambles address/rnw once phi2 has started.
    task automatic do_cycle(input logic [15:0] addr, input logic rnw, input logic [7:0] wd,
                            input logic sync, input bit wiggle);
        exp_t e;
        bit   is_reg;
        wait_phi(1'b0);
        bbc_a = addr; bbc_rnw = rnw; bbc_d_in = wd; bbc_sync = sync;
        is_reg   = (addr[15:4] == 12'hFE4);
        e.hi_len = stretch_m(addr) ? ((idx % 2 == 1) ? 3 * CLK_DIV : 4 * CLK_DIV) : CLK_DIV;
        e.addr = addr; e.sync = sync; e.we = 0; e.wdata = wd; e.rd = 0; e.oe = 0; e.dout = '0;
        if (rnw) begin
            if (is_reg) begin
                e.oe = e.hi_len; e.dout = regs_m[addr[3:0]];
            end else begin
                e.oe = e.hi_len - 1; e.dout = 8'h3C; e.rd = 1;
            end
        end else if (is_reg) begin
            regs_m[addr[3:0]] = wd;
        end else begin
            e.we = 1;
        end
        e.irq_next = !regs_m[15][0];
        q.push_back(e);
        idx++;
        wait_phi(1'b1);
        if (wiggle) begin
            bbc_a = ~addr; bbc_rnw = ~rnw;
        end
        wait_phi(1'b0);
    endtask

    bit          prev_phi0, lo_valid, irq_m, irq_pend;
    int unsigned hi_cnt, lo_cnt, oe_cnt, rd_cnt, we_cnt;
    logic [7:0]  dout_seen;
    logic [15:0] addr_seen, m_cyc, m_sync;
    exp_t        me;

    always @(negedge hsclk) begin
        if (!resetb) begin
            q.delete();
            prev_phi0 = 1'b0; lo_valid = 1'b0; irq_m = 1'b1; irq_pend = 1'b0;
            hi_cnt = 0; lo_cnt = 0; oe_cnt = 0; rd_cnt = 0; we_cnt = 0;
            m_cyc = '0; m_sync = '0;
        end else if (mon_en) begin
            chk("phi1_inv", 32'(bbc_phi1), 32'(!bbc_phi0));
            if (irq_pend) begin
                chk("irqb_after", 32'(irqb), 32'(irq_m));
                irq_pend = 1'b0;
            end
            if (bbc_d_oe) begin oe_cnt++; dout_seen = bbc_d_out; end
            if (mem_rd)   begin rd_cnt++; addr_seen = mem_addr; end
            if (mem_we)   we_cnt++;
            if (bbc_phi0) begin
                if (!prev_phi0 && lo_valid) chk("ph1_len", 32'(lo_cnt), 32'(CLK_DIV));
                hi_cnt++;
            end else begin
                if (prev_phi0) begin
                    if (q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_cycle: bus cycle ended with no expectation queued at %0t", $time);
                    end else begin
                        me = q.pop_front();
                        chk("ph2_len", 32'(hi_cnt), 32'(me.hi_len));
                        chk("oe_cycles", 32'(oe_cnt), 32'(me.oe));
                        if (me.oe > 0) chk("d_out", 32'(dout_seen), 32'(me.dout));
                        chk("mem_rd_pulses", 32'(rd_cnt), 32'(me.rd));
                        if (me.rd > 0) chk("mem_addr", 32'(addr_seen), 32'(me.addr));
                        chk("mem_we_pulses", 32'(we_cnt), 32'(me.we));
                        if (me.we > 0) chk("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
                        chk("irqb_hold", 32'(irqb), 32'(irq_m));
                        irq_m = me.irq_next; irq_pend = 1'b1;
                        m_cyc = m_cyc + 16'd1;
                        if (me.sync) m_sync = m_sync + 16'd1;
                        chk("cyc_cnt", 32'(cyc_cnt), 32'(m_cyc));
                        chk("sync_cnt", 32'(sync_cnt), 32'(m_sync));
                    end
                    hi_cnt = 0; lo_cnt = 0; oe_cnt = 0; rd_cnt = 0; we_cnt = 0;
                    lo_valid = 1'b1;
                end
                lo_cnt++;
            end
            prev_phi0 = bbc_phi0;
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge hsclk);
        chk("rst_phi0", 32'(bbc_phi0), 32'd0);
        chk("rst_phi1", 32'(bbc_phi1), 32'd1);
        chk("rst_d_oe", 32'(bbc_d_oe), 32'd0);
        chk("rst_d_out", 32'(bbc_d_out), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_irqb", 32'(irqb), 32'd1);
        chk("rst_cyc_cnt", 32'(cyc_cnt), 32'd0);
        chk("rst_sync_cnt", 32'(sync_cnt), 32'd0);
        resetb = 1'b1;
        mon_en = 1'b1;

        repeat (3) do_cycle(16'h0000, 1'b1, 8'h00, 1'b0, 1'b0);
        do_cycle(16'h1234, 1'b1, 8'h00, 1'b1, 1'b0);
        do_cycle(16'hFE45, 1'b0, 8'hA5, 1'b0, 1'b0);
        do_cycle(16'hFE45, 1'b1, 8'h00, 1'b1, 1'b0);
        do_cycle(16'h8000, 1'b1, 8'h00, 1'b1, 1'b1);
        do_cycle(16'hFC10, 1'b0, 8'h55, 1'b0, 1'b0);
        do_cycle(16'hFC10, 1'b0, 8'h55, 1'b0, 1'b0);
        do_cycle(16'hFE1F, 1'b1, 8'h00, 1'b0, 1'b0);
        do_cycle(16'hFE20, 1'b1, 8'h00, 1'b0, 1'b0);
        do_cycle(16'hFE7F, 1'b1, 8'h00, 1'b0, 1'b0);
        do_cycle(16'hFEBF, 1'b1, 8'h00, 1'b0, 1'b0);
        do_cycle(16'hFEDF, 1'b1, 8'h00, 1'b0, 1'b0);
        do_cycle(16'hFEE0, 1'b1, 8'h00, 1'b0, 1'b0);
        do_cycle(16'hFE4F, 1'b0, 8'h01, 1'b0, 1'b0);
        do_cycle(16'hFE4F, 1'b1, 8'h00, 1'b0, 1'b0);
        do_cycle(16'hFE4F, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset during phi2 of a memory write: nothing may be committed.
        wait_phi(1'b0);
        bbc_a = 16'h2000; bbc_rnw = 1'b0; bbc_d_in = 8'h77; bbc_sync = 1'b1;
        wait_phi(1'b1);
        repeat (2) @(negedge hsclk);
        resetb = 1'b0;
        #1;
        chk("midrst_phi0", 32'(bbc_phi0), 32'd0);
        chk("midrst_d_oe", 32'(bbc_d_oe), 32'd0);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge hsclk);
            chk("midrst_no_we", 32'(mem_we), 32'd0);
        end
        model_reset();
        resetb = 1'b1;
        #1;
        chk("post_rst_cyc_cnt", 32'(cyc_cnt), 32'd0);
        chk("post_rst_sync_cnt", 32'(sync_cnt), 32'd0);
        @(negedge hsclk);
        do_cycle(16'h2000, 1'b0, 8'h88, 1'b0, 1'b0);
        do_cycle(16'hFE45, 1'b1, 8'h00, 1'b0, 1'b0);

        repeat (2) @(negedge hsclk);
        mon_en = 1'b0;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
